// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side end of the GPU data-memory channel
// interface. Per-channel read/write requests are arbitrated round-robin
// onto a single-port word array; each completion is signalled by a
// one-cycle ready pulse LATENCY cycles after the grant.
// Ports:
//   clk, reset           clock, async active-high reset
//   mem_read_*           per-channel read request / ready / data
//   mem_write_*          per-channel write request / ready
//   stat_*               grant and stall counters (DATA_MEM_STATS_EN only)
// Optional feature macro: DATA_MEM_STATS_EN
module data_mem_responder #(
    parameter int ADDR_BITS    = 12,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 16,
    parameter int LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [31:0]             stat_read_count,
    output logic [31:0]             stat_write_count,
    output logic [31:0]             stat_stall_cycles
`endif
);

    localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [PW:0]   NCH      = (PW+1)'(NUM_CHANNELS);
    localparam logic [PW-1:0] LAST     = PW'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_ACK,
        S_HOLD
    } state_t;

    state_t                  r_state [NUM_CHANNELS];
    state_t                  w_nxt   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_kind;
    logic [ADDR_BITS-1:0]    r_addr  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    r_wdata [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    r_cap   [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    r_rdata [NUM_CHANNELS];
    logic [CW-1:0]           r_cnt   [NUM_CHANNELS];
    logic [PW-1:0]           r_ptr;
    logic [DATA_BITS-1:0]    r_mem   [2**ADDR_BITS];

    logic                    w_gnt_vld;
    logic [PW-1:0]           w_gnt_idx;
    logic [NUM_CHANNELS-1:0] w_gnt_oh;
    logic [NUM_CHANNELS-1:0] w_req;
    logic [NUM_CHANNELS-1:0] w_svc;
    logic [NUM_CHANNELS-1:0] w_new;
    logic [PW:0]             w_k;
    logic [ADDR_BITS-1:0]    w_gnt_addr;
    logic [DATA_BITS-1:0]    w_mem_q;

    // r_kind=1 marks a write; the valid being serviced follows the kind.
    assign w_svc = (r_kind & mem_write_valid) | (~r_kind & mem_read_valid);
    assign w_new = mem_read_valid | mem_write_valid;

    // Round-robin: first channel in REQ scanning upward from r_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        w_req     = '0;
        w_k       = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            w_req[i] = (r_state[i] == S_REQ);
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_k = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_k >= NCH)
                w_k = w_k - NCH;
            if (!w_gnt_vld && w_req[w_k[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_k[PW-1:0];
            end
        end
        if (w_gnt_vld)
            w_gnt_oh[w_gnt_idx] = 1'b1;
    end

    assign w_gnt_addr = r_addr[w_gnt_idx];
    assign w_mem_q    = r_mem[w_gnt_addr];

    // The array is deliberately not reset; granted writes survive reset.
    always_ff @(posedge clk) begin
        if (w_gnt_vld && r_kind[w_gnt_idx])
            r_mem[w_gnt_addr] <= r_wdata[w_gnt_idx];
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_nxt[i] = r_state[i];
            unique case (r_state[i])
                S_IDLE: if (w_new[i]) w_nxt[i] = S_REQ;
                S_REQ:  if (w_gnt_oh[i])
                            w_nxt[i] = (LATENCY == 1) ? S_ACK : S_BUSY;
                // Counter at 1 means this edge is the last BUSY edge.
                S_BUSY: if (r_cnt[i] <= CW'(1)) w_nxt[i] = S_ACK;
                S_ACK:  w_nxt[i] = w_svc[i] ? S_HOLD : S_IDLE;
                S_HOLD: if (!w_svc[i]) w_nxt[i] = S_IDLE;
                default: w_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= '0;
            r_kind <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_state[i] <= S_IDLE;
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_cap[i]   <= '0;
                r_rdata[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            if (w_gnt_vld)
                r_ptr <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_state[i] <= w_nxt[i];
                if (r_state[i] == S_IDLE && w_new[i]) begin
                    r_kind[i]  <= mem_write_valid[i];
                    r_addr[i]  <= mem_write_valid[i] ?
                                  mem_write_address[i] :
                                  mem_read_address[i];
                    r_wdata[i] <= mem_write_data[i];
                end
                if (w_gnt_oh[i]) begin
                    r_cnt[i] <= CNT_LOAD;
                    if (!r_kind[i]) begin
                        if (LATENCY == 1)
                            r_rdata[i] <= w_mem_q;
                        else
                            r_cap[i] <= w_mem_q;
                    end
                end
                // Output data changes only when the read completes.
                if (r_state[i] == S_BUSY) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                    if (r_cnt[i] <= CW'(1) && !r_kind[i])
                        r_rdata[i] <= r_cap[i];
                end
            end
        end
    end

    always_comb begin
        mem_read_ready  = '0;
        mem_write_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mem_read_ready[i]  = (r_state[i] == S_ACK) && !r_kind[i];
            mem_write_ready[i] = (r_state[i] == S_ACK) && r_kind[i];
        end
    end

    assign mem_read_data = r_rdata;

`ifdef DATA_MEM_STATS_EN
    logic [31:0] r_st_rd;
    logic [31:0] r_st_wr;
    logic [31:0] r_st_stall;
    logic        w_stall;

    // Any REQ channel left over after the grant is a stalled channel.
    assign w_stall = |(w_req & ~w_gnt_oh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st_rd    <= '0;
            r_st_wr    <= '0;
            r_st_stall <= '0;
        end else begin
            if (w_gnt_vld && !r_kind[w_gnt_idx] && r_st_rd != '1)
                r_st_rd <= r_st_rd + 1'b1;
            if (w_gnt_vld && r_kind[w_gnt_idx] && r_st_wr != '1)
                r_st_wr <= r_st_wr + 1'b1;
            if (w_stall && r_st_stall != '1)
                r_st_stall <= r_st_stall + 1'b1;
        end
    end

    assign stat_read_count   = r_st_rd;
    assign stat_write_count  = r_st_wr;
    assign stat_stall_cycles = r_st_stall;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, 16 channels).
// Checks timing, arbitration order, ordering and reset behaviour.
module tb_data_mem_responder;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int NC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] rv;
    logic [NC-1:0] rrdy;
    logic [NC-1:0] wv;
    logic [NC-1:0] wrdy;
    logic [AW-1:0] ra [NC];
    logic [AW-1:0] wa [NC];
    logic [DW-1:0] rd [NC];
    logic [DW-1:0] wd [NC];
`ifdef DATA_MEM_STATS_EN
    logic [31:0]   st_rd;
    logic [31:0]   st_wr;
    logic [31:0]   st_stall;
`endif

    logic [DW-1:0] model [1<<AW];
    int            n_vec = 0;
    int            n_err = 0;
    int            n;
    int            q_ch [$];
    int            q_t  [$];

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (ra),
        .mem_read_ready    (rrdy),
        .mem_read_data     (rd),
        .mem_write_valid   (wv),
        .mem_write_address (wa),
        .mem_write_data    (wd),
        .mem_write_ready   (wrdy)
`ifdef DATA_MEM_STATS_EN
        ,
        .stat_read_count   (st_rd),
        .stat_write_count  (st_wr),
        .stat_stall_cycles (st_stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        rv    = '0;
        wv    = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int lat);
        int k;
        k = 0;
        wa[ch] = a;
        wd[ch] = d;
        wv[ch] = 1'b1;
        while (k < 20) begin
            tick;
            k++;
            if (wrdy[ch]) break;
        end
        chk("wr_lat", k, lat);
        wv[ch] = 1'b0;
        model[a] = d;
        tick;
        chk("wr_pulse", 32'(wrdy[ch]), 0);
    endtask

    task automatic rdt(input int ch, input logic [AW-1:0] a, input int lat);
        int k;
        k = 0;
        ra[ch] = a;
        rv[ch] = 1'b1;
        while (k < 20) begin
            tick;
            k++;
            if (rrdy[ch]) break;
        end
        chk("rd_lat", k, lat);
        chk("rd_data", 32'(rd[ch]), 32'(model[a]));
        rv[ch] = 1'b0;
        tick;
        chk("rd_pulse", 32'(rrdy[ch]), 0);
        chk("rd_hold", 32'(rd[ch]), 32'(model[a]));
    endtask

    // Raise reads on every channel in mask; log (channel, tick) of each pulse.
    task automatic run_reads(input logic [NC-1:0] mask);
        logic [NC-1:0] pend;
        int t;
        q_ch.delete();
        q_t.delete();
        pend = mask;
        rv = rv | mask;
        t = 0;
        while (pend != '0 && t < 40) begin
            tick;
            t++;
            for (int c = 0; c < NC; c++) begin
                if (rrdy[c]) begin
                    q_ch.push_back(c);
                    q_t.push_back(t);
                    chk("rr_data", 32'(rd[c]), 32'(model[ra[c]]));
                    pend[c] = 1'b0;
                    rv[c] = 1'b0;
                end
            end
        end
        chk("rr_done", 32'(pend), 0);
        tick;
    endtask

    task automatic exp_order(input int idx, input int ch, input int t);
        if (idx < q_ch.size()) begin
            chk("order_ch", q_ch[idx], ch);
            chk("order_t", q_t[idx], t);
        end else begin
            chk("order_missing", q_ch.size(), idx + 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        rv = '0;
        wv = '0;
        for (int c = 0; c < NC; c++) begin
            ra[c] = '0;
            wa[c] = '0;
            wd[c] = '0;
        end
        tick;
        tick;
        chk("rst_rrdy", 32'(rrdy), 0);
        chk("rst_wrdy", 32'(wrdy), 0);
        chk("rst_rd0", 32'(rd[0]), 0);
        chk("rst_rd15", 32'(rd[15]), 0);
        reset = 1'b0;

        // single write then read, uncontested: 3 edges each
        wr(0, 12'h010, 16'h1234, 3);
        rdt(0, 12'h010, 3);
        wr(1, 12'h020, 16'hAAAA, 3);
        wr(2, 12'h030, 16'h5555, 3);
        wr(3, 12'h040, 16'h0F0F, 3);
        wr(4, 12'h000, 16'h8001, 3);
        rdt(4, 12'h000, 3);

        // contention from pointer 0
        do_reset;
        chk("rst2_rd0", 32'(rd[0]), 0);
        ra[0] = 12'h010;
        ra[1] = 12'h020;
        ra[2] = 12'h030;
        ra[3] = 12'h040;
        run_reads(16'h000F);
        chk("cont_n", q_ch.size(), 4);
        exp_order(0, 0, 3);
        exp_order(1, 1, 4);
        exp_order(2, 2, 5);
        exp_order(3, 3, 6);
`ifdef DATA_MEM_STATS_EN
        chk("st_rd", st_rd, 4);
        chk("st_wr", st_wr, 0);
        chk("st_stall", st_stall, 3);
`endif
        // pointer now 4: ch5 must beat ch3
        ra[5] = 12'h020;
        run_reads(16'h0028);
        exp_order(0, 5, 3);
        exp_order(1, 3, 4);

        // same-channel write+read at top address: write wins
        ra[5] = 12'hFFF;
        wa[5] = 12'hFFF;
        wd[5] = 16'hBEEF;
        rv[5] = 1'b1;
        wv[5] = 1'b1;
        n = 0;
        while (n < 20) begin
            tick;
            n++;
            if (wrdy[5]) break;
        end
        chk("rw_wlat", n, 3);
        chk("rw_rrdy_low", 32'(rrdy[5]), 0);
        wv[5] = 1'b0;
        model[12'hFFF] = 16'hBEEF;
        n = 0;
        while (n < 20) begin
            tick;
            n++;
            if (rrdy[5]) break;
        end
        chk("rw_rlat", n, 4);
        chk("rw_data", 32'(rd[5]), 32'h0000BEEF);
        rv[5] = 1'b0;
        tick;

        // pointer to 15, then 15 and 0 contend twice
        rdt(14, 12'h010, 3);
        ra[15] = 12'h020;
        ra[0]  = 12'h030;
        run_reads(16'h8001);
        exp_order(0, 15, 3);
        exp_order(1, 0, 4);
        run_reads(16'h8001);
        exp_order(0, 15, 3);
        exp_order(1, 0, 4);

        // reset right after a write grant: write persists
        wa[1] = 12'h050;
        wd[1] = 16'h7777;
        wv[1] = 1'b1;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("rstw_wrdy", 32'(wrdy), 0);
        wv[1] = 1'b0;
        model[12'h050] = 16'h7777;
        tick;
        reset = 1'b0;
        rdt(1, 12'h050, 3);

        // reset while ch2 read is BUSY: no pulse, old data intact
        ra[2] = 12'h030;
        rv[2] = 1'b1;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("rstr_rrdy", 32'(rrdy), 0);
        chk("rstr_wrdy", 32'(wrdy), 0);
        chk("rstr_rd2", 32'(rd[2]), 0);
        rv[2] = 1'b0;
        tick;
        chk("rstr_rrdy2", 32'(rrdy), 0);
        reset = 1'b0;
        tick;
        chk("rstr_rrdy3", 32'(rrdy), 0);
        rdt(2, 12'h030, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
